// File: rtl/sdram_pkg.sv
// Shared types, constants and the data-pattern generator for the SDRAM traffic checker.
package sdram_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_DONE
  } state_t;

  localparam logic [1:0] MODE_INDEX  = 2'd0;
  localparam logic [1:0] MODE_LFSR   = 2'd1;
  localparam logic [1:0] MODE_WALK1  = 2'd2;
  localparam logic [1:0] MODE_NINDEX = 2'd3;

  // Right-shifting Galois form, taps 32,22,2,1
  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

  // Full 32-bit pattern word; the caller keeps the low data_w bits
  function automatic logic [31:0] pattern(input logic [1:0]  mode,
                                          input logic [31:0] index,
                                          input logic [31:0] lfsr,
                                          input int unsigned data_w);
    logic [31:0] p;
    p = index;
    case (mode)
      MODE_INDEX:  p = index;
      MODE_LFSR:   p = lfsr;
      MODE_WALK1:  p = 32'd1 << (index % data_w);
      MODE_NINDEX: p = ~index;
      default:     p = index;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/lfsr_galois.sv
// Galois LFSR with synchronous reload and single-step enable.
module lfsr_galois #(
  parameter int unsigned       WIDTH = 32,
  parameter logic [WIDTH-1:0]  POLY  = '1,
  parameter logic [WIDTH-1:0]  SEED  = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  output logic [WIDTH-1:0] value
);

  // Reload wins over step so a phase restart always begins at SEED
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       value <= SEED;
    else if (load) value <= SEED;
    else if (step) value <= {1'b0, value[WIDTH-1:1]} ^ (value[0] ? POLY : '0);
  end

endmodule

// File: rtl/sdram_traffic_chk.sv
// SDRAM exerciser: fills an address window with a pattern, reads it back and compares.
module sdram_traffic_chk
  import sdram_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 23,
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       NUM_WORDS = 1024,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int unsigned       STRIDE    = 1,
  parameter logic [31:0]       LFSR_SEED = 32'hACE1_2468,
  parameter int unsigned       ERR_W     = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic [1:0]        i_mode,
  output logic [ADDR_W-1:0] o_addr,
  output logic [DATA_W-1:0] o_wdata,
  output logic              o_wr_req,
  output logic              o_rd_req,
  input  logic              i_ready,
  input  logic [DATA_W-1:0] i_rdata,
  input  logic              i_rd_valid,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_pass,
  output logic [ERR_W-1:0]  o_err_cnt,
  output logic [ADDR_W-1:0] o_first_err_addr
);

  localparam int unsigned      IDX_W    = $clog2(NUM_WORDS + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  state_t             state, next_state;
  logic [IDX_W-1:0]   idx;
  logic [ADDR_W-1:0]  addr_q;
  logic [1:0]         mode_q;
  logic [ERR_W-1:0]   err_cnt;
  logic [ADDR_W-1:0]  first_err;
  logic [31:0]        lfsr_val;
  logic [31:0]        pat;
  logic               start_go, wr_acc, rd_acc, rd_done, last, mismatch;
  logic               lfsr_load, lfsr_step;

  // Abort masks every event so nothing advances in the cycle it is seen
  assign start_go  = i_start && !i_abort && (state == ST_IDLE || state == ST_DONE);
  assign wr_acc    = (state == ST_WR)      && i_ready    && !i_abort;
  assign rd_acc    = (state == ST_RD_REQ)  && i_ready    && !i_abort;
  assign rd_done   = (state == ST_RD_WAIT) && i_rd_valid && !i_abort;
  assign last      = (idx == LAST_IDX);
  assign pat       = pattern(mode_q, 32'(idx), lfsr_val, DATA_W);
  assign mismatch  = (i_rdata != pat[DATA_W-1:0]);
  assign lfsr_load = start_go || (wr_acc && last);
  assign lfsr_step = (wr_acc && !last) || rd_done;

  // One generator serves both phases; it is reseeded between them
  lfsr_galois #(
    .WIDTH (32),
    .POLY  (LFSR_POLY),
    .SEED  (LFSR_SEED)
  ) u_lfsr (
    .clk   (i_clk),
    .rst   (i_rst),
    .load  (lfsr_load),
    .step  (lfsr_step),
    .value (lfsr_val)
  );

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= ST_IDLE;
    else       state <= next_state;
  end

  // Next-state logic; abort overrides every transition
  always_comb begin
    next_state = state;
    unique case (state)
      ST_IDLE:    if (start_go) next_state = ST_WR;
      ST_WR:      if (wr_acc && last) next_state = ST_RD_REQ;
      ST_RD_REQ:  if (rd_acc) next_state = ST_RD_WAIT;
      ST_RD_WAIT: if (rd_done) next_state = last ? ST_DONE : ST_RD_REQ;
      ST_DONE:    if (start_go) next_state = ST_WR;
      default:    next_state = ST_IDLE;
    endcase
    if (i_abort) next_state = ST_IDLE;
  end

  // Outputs decoded from the current state
  always_comb begin
    o_wr_req = (state == ST_WR);
    o_rd_req = (state == ST_RD_REQ);
    o_busy   = (state == ST_WR) || (state == ST_RD_REQ) || (state == ST_RD_WAIT);
    o_done   = (state == ST_DONE);
    o_pass   = (state == ST_DONE) && (err_cnt == '0);
  end

  // Index, address, mode and error bookkeeping
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      idx       <= '0;
      addr_q    <= '0;
      mode_q    <= MODE_INDEX;
      err_cnt   <= '0;
      first_err <= '0;
    end else if (start_go) begin
      idx       <= '0;
      addr_q    <= BASE_ADDR;
      mode_q    <= i_mode;
      err_cnt   <= '0;
      first_err <= '0;
    end else if (wr_acc) begin
      if (last) begin
        idx    <= '0;
        addr_q <= BASE_ADDR;
      end else begin
        idx    <= idx + 1'b1;
        addr_q <= addr_q + ADDR_W'(STRIDE);
      end
    end else if (rd_done) begin
      idx    <= idx + 1'b1;
      addr_q <= addr_q + ADDR_W'(STRIDE);
      if (mismatch) begin
        if (err_cnt == '0) first_err <= addr_q;
        if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
      end
    end
  end

  assign o_addr           = addr_q;
  assign o_wdata          = pat[DATA_W-1:0];
  assign o_err_cnt        = err_cnt;
  assign o_first_err_addr = first_err;

endmodule
